cache_arbiter: RTL and testbench



---
 rtl/cache_arb_pkg.sv | 15 +
 rtl/cache_arb_pick.sv | 28 ++
 rtl/cache_arbiter.sv | 115 +++++++++++
 tb/tb_cache_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types for the cache arbiter: FSM state encoding and grant identifiers.
package cache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational winner select between icache and dcache requests.
// Optional feature macro: CACHE_ARB_RR_EN (round-robin on simultaneous requests).
// Without it the dcache has fixed priority and no rr_last input exists.
module cache_arb_pick
   import cache_arb_pkg::*;
(
   input  logic   i_req,
   input  logic   d_req,
`ifdef CACHE_ARB_RR_EN
   input  grant_t rr_last,
`endif
   output grant_t grant
);

   // Winner select; the result only matters when at least one request is pending.
   always_comb begin
      grant = GNT_D;
      if (i_req && !d_req) begin
         grant = GNT_I;
      end
`ifdef CACHE_ARB_RR_EN
      else if (i_req && d_req && (rr_last == GNT_D)) begin
         grant = GNT_I;
      end
`endif
   end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the L1 icache and L1 dcache.
// One line transaction at a time; the grant is held until pmem_resp, and the
// resp pulse is steered combinationally to the winner in the pmem_resp cycle.
// Optional feature macro: CACHE_ARB_RR_EN. When defined, simultaneous requests
// alternate using rr_last; otherwise the dcache always wins a tie.
module cache_arbiter
   import cache_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic              pmem_resp,
   input  logic [LINE_W-1:0] pmem_rdata
);

   arb_state_t state;
   grant_t     grant;
   logic       d_req;

`ifdef CACHE_ARB_RR_EN
   grant_t     rr_last;
`endif

   assign d_req = d_read | d_write;

   cache_arb_pick u_pick (
      .i_req   (i_read),
      .d_req   (d_req),
`ifdef CACHE_ARB_RR_EN
      .rr_last (rr_last),
`endif
      .grant   (grant)
   );

   // Grant FSM: IDLE picks a winner, SERVE holds it until memory answers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
`ifdef CACHE_ARB_RR_EN
         rr_last <= GNT_I;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_read || d_req) begin
                  state <= (grant == GNT_I) ? SERVE_I : SERVE_D;
`ifdef CACHE_ARB_RR_EN
                  rr_last <= grant;
`endif
               end
            end
            SERVE_I: begin
               if (pmem_resp) state <= IDLE;
            end
            SERVE_D: begin
               if (pmem_resp) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Port steering from the registered state; strobes vanish as soon as reset forces IDLE.
   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      case (state)
         SERVE_I: begin
            pmem_read    = i_read;
            pmem_address = i_address;
            i_resp       = pmem_resp;
         end
         SERVE_D: begin
            pmem_read    = d_read;
            pmem_write   = d_write;
            pmem_address = d_address;
            pmem_wdata   = d_wdata;
            d_resp       = pmem_resp;
         end
         default: ;
      endcase
   end

   // Read data goes straight through; only the granted side gets a resp.
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

   // A dcache read and write-back at once has no meaning.
   a_no_rw_both: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

   // The granted requester must keep its request up until it sees resp.
   a_i_held: assert property (@(posedge clk) disable iff (rst) (state == SERVE_I) |-> i_read);
   a_d_held: assert property (@(posedge clk) disable iff (rst) (state == SERVE_D) |-> d_req);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a small latency-programmable memory model.
module tb_cache_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic              i_resp;
   logic [LINE_W-1:0] i_rdata;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [LINE_W-1:0] d_wdata;
   logic              d_resp;
   logic [LINE_W-1:0] d_rdata;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_resp;
   logic [LINE_W-1:0] pmem_rdata;

   logic auto_resp = 1'b0;
   logic man_resp  = 1'b0;
   int   mem_lat   = 4;
   int   mem_cnt   = 0;
   int   checks    = 0;
   int   errors    = 0;

   assign pmem_resp = auto_resp | man_resp;

   cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_resp       (i_resp),
      .i_rdata      (i_rdata),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_address    (d_address),
      .d_wdata      (d_wdata),
      .d_resp       (d_resp),
      .d_rdata      (d_rdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [LINE_W-1:0] mdl(input logic [ADDR_W-1:0] a);
      return {8{a ^ 32'hA5A5_0F0F}};
   endfunction

   // Memory: answers a strobe after mem_lat falling edges with a one-cycle resp.
   always @(negedge clk) begin
      if (rst) begin
         auto_resp = 1'b0;
         mem_cnt   = 0;
      end else if (auto_resp) begin
         auto_resp = 1'b0;
         mem_cnt   = 0;
      end else if (pmem_read || pmem_write) begin
         if (mem_cnt == mem_lat - 1) begin
            auto_resp  = 1'b1;
            pmem_rdata = mdl(pmem_address);
         end else begin
            mem_cnt++;
         end
      end else begin
         mem_cnt = 0;
      end
   end

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits on falling edges for any resp; n = falling edges consumed, -1 on timeout.
   task automatic wait_resp(output int n);
      n = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         #1;
         if (i_resp || d_resp) begin
            n = k;
            break;
         end
      end
      if (n < 0) chk("resp_timeout", 1'b0, 1'b1);
   endtask

   int                n;
   logic              ri, rd, dw;
   logic              first_is_i;
   logic [ADDR_W-1:0] ia, da;
   logic [LINE_W-1:0] dwd;
   int                gi, gd, budget;

   initial begin
      rst        = 1'b1;
      i_read     = 1'b0;
      i_address  = '0;
      d_read     = 1'b0;
      d_write    = 1'b0;
      d_address  = '0;
      d_wdata    = '0;
      pmem_rdata = '0;
      tick();
      tick();
      chk("rst_pmem_read", pmem_read, 1'b0);
      chk("rst_pmem_write", pmem_write, 1'b0);
      chk("rst_i_resp", i_resp, 1'b0);
      chk("rst_d_resp", d_resp, 1'b0);
      chk("rst_pmem_address", pmem_address, '0);
      chk("rst_pmem_wdata", pmem_wdata, '0);
      rst = 1'b0;
      tick();

      // icache read alone, memory latency 4
      mem_lat   = 4;
      i_read    = 1'b1;
      i_address = 32'h0000_0040;
      #1;
      chk("t1_no_strobe_yet", pmem_read, 1'b0);
      tick();
      chk("t1_pmem_read", pmem_read, 1'b1);
      chk("t1_pmem_address", pmem_address, 32'h40);
      chk("t1_pmem_write", pmem_write, 1'b0);
      wait_resp(n);
      chk("t1_latency", n, 4);
      chk("t1_i_resp", i_resp, 1'b1);
      chk("t1_d_resp", d_resp, 1'b0);
      chk("t1_i_rdata", i_rdata, mdl(32'h40));
      tick();
      i_read = 1'b0;
      #1;
      chk("t1_i_resp_pulse", i_resp, 1'b0);
      chk("t1_idle_strobe", pmem_read, 1'b0);
      tick();

      // dcache write-back alone
      mem_lat   = 2;
      d_write   = 1'b1;
      d_address = 32'h0000_1000;
      d_wdata   = {8{32'hDEAD_BEEF}};
      tick();
      chk("t2_pmem_write", pmem_write, 1'b1);
      chk("t2_pmem_read", pmem_read, 1'b0);
      chk("t2_pmem_address", pmem_address, 32'h1000);
      chk("t2_pmem_wdata", pmem_wdata, {8{32'hDEAD_BEEF}});
      wait_resp(n);
      chk("t2_d_resp", d_resp, 1'b1);
      chk("t2_i_resp", i_resp, 1'b0);
      tick();
      d_write = 1'b0;
      #1;
      chk("t2_d_resp_once", d_resp, 1'b0);
      tick();

      // simultaneous reads; last grant was dcache
`ifdef CACHE_ARB_RR_EN
      first_is_i = 1'b1;
`else
      first_is_i = 1'b0;
`endif
      mem_lat   = 3;
      i_read    = 1'b1;
      i_address = 32'h0000_0100;
      d_read    = 1'b1;
      d_address = 32'h0000_0200;
      tick();
      chk("t3_first_addr", pmem_address, first_is_i ? 32'h100 : 32'h200);
      chk("t3_first_read", pmem_read, 1'b1);
      wait_resp(n);
      chk("t3_first_i_resp", i_resp, first_is_i);
      chk("t3_first_d_resp", d_resp, !first_is_i);
      tick();
      if (first_is_i) i_read = 1'b0;
      else d_read = 1'b0;
      #1;
      chk("t3_gap_read", pmem_read, 1'b0);
      tick();
      chk("t3_second_addr", pmem_address, first_is_i ? 32'h200 : 32'h100);
      chk("t3_second_read", pmem_read, 1'b1);
      wait_resp(n);
      chk("t3_second_i_resp", i_resp, !first_is_i);
      chk("t3_second_d_resp", d_resp, first_is_i);
      chk("t3_second_rdata", first_is_i ? d_rdata : i_rdata, mdl(first_is_i ? 32'h200 : 32'h100));
      tick();
      i_read = 1'b0;
      d_read = 1'b0;
      tick();

      // stray pmem_resp in IDLE
      man_resp = 1'b1;
      #1;
      chk("t4_i_resp", i_resp, 1'b0);
      chk("t4_d_resp", d_resp, 1'b0);
      tick();
      chk("t4_still_idle_read", pmem_read, 1'b0);
      chk("t4_still_idle_write", pmem_write, 1'b0);
      chk("t4_i_resp_after", i_resp, 1'b0);
      man_resp = 1'b0;
      tick();

      // reset between edges during a write-back
      mem_lat   = 30;
      d_write   = 1'b1;
      d_address = 32'h0000_2000;
      d_wdata   = {8{32'h1234_5678}};
      tick();
      chk("t5_write_before_rst", pmem_write, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_write_dropped", pmem_write, 1'b0);
      chk("t5_addr_cleared", pmem_address, '0);
      d_write   = 1'b0;
      i_read    = 1'b1;
      i_address = 32'h0000_0080;
      mem_lat   = 3;
      @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      tick();
      chk("t5_i_granted", pmem_read, 1'b1);
      chk("t5_i_addr", pmem_address, 32'h80);
      wait_resp(n);
      chk("t5_i_resp", i_resp, 1'b1);
      chk("t5_i_rdata", i_rdata, mdl(32'h80));
      tick();
      i_read = 1'b0;
      tick();

      // random mix against the memory model
      for (int t = 0; t < 200; t++) begin
         ri = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 1));
         if (!ri && !rd) ri = 1'b1;
         dw  = 1'($urandom_range(0, 1));
         ia  = $urandom & 32'hFFFF_FFE0;
         da  = $urandom & 32'hFFFF_FFE0;
         dwd = {8{$urandom}};
         mem_lat   = $urandom_range(1, 6);
         i_read    = ri;
         i_address = ia;
         d_read    = rd && !dw;
         d_write   = rd && dw;
         d_address = da;
         d_wdata   = dwd;
         gi = 0;
         gd = 0;
         budget = 0;
         while (((ri && gi == 0) || (rd && gd == 0)) && budget < 40) begin
            budget++;
            @(negedge clk);
            #1;
            if (i_resp) begin
               gi++;
               chk("rnd_i_rdata", i_rdata, mdl(ia));
            end
            if (d_resp) begin
               gd++;
               if (dw) chk("rnd_d_wdata", pmem_wdata, dwd);
               else chk("rnd_d_rdata", d_rdata, mdl(da));
            end
            tick();
            if (gi > 0) i_read = 1'b0;
            if (gd > 0) begin
               d_read  = 1'b0;
               d_write = 1'b0;
            end
         end
         chk("rnd_i_count", gi, {31'd0, ri});
         chk("rnd_d_count", gd, {31'd0, rd});
         i_read  = 1'b0;
         d_read  = 1'b0;
         d_write = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
